// File: rtl/bru_pred_pkg.sv
// rtl/bru_pred_pkg.sv - shared widths, reset vector and branch counter helpers for bru_pred
package bru_pred_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h8000_0000;
    localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_e;

    function automatic ctr_e ctr_inc(input ctr_e c);
        return (c == CTR_ST) ? CTR_ST : ctr_e'(c + 2'd1);
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bru_pred_if.sv
// rtl/bru_pred_if.sv - fetch handshake and resolve bundle between bru_pred, IFU and WBU
interface bru_pred_if;
    import bru_pred_pkg::*;

    logic [XLEN-1:0] o_pc;
    logic            o_pc_valid;
    logic            i_pc_ready;
    logic            i_res_valid;
    logic [XLEN-1:0] i_res_pc;
    logic [XLEN-1:0] i_res_imm;
    logic [XLEN-1:0] i_res_rs1;
    logic            i_res_is_jal;
    logic            i_res_is_jalr;
    logic            i_res_is_br;
    logic            i_res_br_taken;
    logic            o_flush;
    logic [31:0]     o_mispred_cnt;

    modport master (
        output o_pc, o_pc_valid, o_flush, o_mispred_cnt,
        input  i_pc_ready, i_res_valid, i_res_pc, i_res_imm, i_res_rs1,
        input  i_res_is_jal, i_res_is_jalr, i_res_is_br, i_res_br_taken
    );

    modport slave (
        input  o_pc, o_pc_valid, o_flush, o_mispred_cnt,
        output i_pc_ready, i_res_valid, i_res_pc, i_res_imm, i_res_rs1,
        output i_res_is_jal, i_res_is_jalr, i_res_is_br, i_res_br_taken
    );

endinterface

// File: rtl/bru_btb.sv
// rtl/bru_btb.sv - direct-mapped BTB: fetch lookup port, resolve lookup port, registered write port
module bru_btb
    import bru_pred_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:2] lk_pc,
    output logic            lk_taken,
    output logic [XLEN-1:0] lk_target,
    input  logic [XLEN-1:2] rs_pc,
    output logic            rs_hit,
    output ctr_e            rs_ctr,
    output logic [XLEN-1:0] rs_target,
    input  logic            wr_en,
    input  logic [XLEN-1:2] wr_pc,
    input  logic [XLEN-1:0] wr_target,
    input  ctr_e            wr_ctr,
    input  logic            wr_uncond
);
    localparam int IDX = $clog2(DEPTH);
    localparam int TW  = XLEN - 2 - IDX;

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] uncond;
    logic [TW-1:0]    tag    [DEPTH];
    logic [XLEN-1:0]  target [DEPTH];
    ctr_e             ctr    [DEPTH];

    logic [IDX-1:0] lk_idx, rs_idx, wr_idx;
    logic           lk_hit;

    assign lk_idx = lk_pc[IDX+1:2];
    assign rs_idx = rs_pc[IDX+1:2];
    assign wr_idx = wr_pc[IDX+1:2];

    assign lk_hit    = valid[lk_idx] && (tag[lk_idx] == lk_pc[XLEN-1:IDX+2]);
    assign lk_taken  = lk_hit && (uncond[lk_idx] || ctr[lk_idx] >= CTR_WT);
    assign lk_target = target[lk_idx];

    assign rs_hit    = valid[rs_idx] && (tag[rs_idx] == rs_pc[XLEN-1:IDX+2]);
    assign rs_ctr    = ctr[rs_idx];
    assign rs_target = target[rs_idx];

    // Only the valid bits need clearing; stale payload is masked by valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx]  <= 1'b1;
            uncond[wr_idx] <= wr_uncond;
            tag[wr_idx]    <= wr_pc[XLEN-1:IDX+2];
            target[wr_idx] <= wr_target;
            ctr[wr_idx]    <= wr_ctr;
        end
    end

endmodule

// File: rtl/bru_pred.sv
// rtl/bru_pred.sv - fetch PC owner with BTB prediction, in-order resolve and mispredict redirect
module bru_pred
    import bru_pred_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int              BTB_DEPTH    = 16,
    parameter int              INFLIGHT     = 2
) (
    input logic        clk,
    input logic        rst,
    bru_pred_if.master bus
);
    localparam int PW = $clog2(INFLIGHT);
    localparam int CW = $clog2(INFLIGHT + 1);

    logic [XLEN-1:0] pc;
    logic            started;
    logic            flush;
    logic [31:0]     mispred_cnt;
    logic [XLEN-1:0] fifo_pc  [INFLIGHT];
    logic [XLEN-1:0] fifo_npc [INFLIGHT];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic            lk_taken, rs_hit;
    logic [XLEN-1:0] lk_target, rs_target, pred_npc, actual_npc, wr_target;
    ctr_e            rs_ctr, wr_ctr;
    logic            wr_en, wr_uncond, fire, mispred;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    bru_btb #(.DEPTH(BTB_DEPTH)) u_btb (
        .clk       (clk),
        .rst       (rst),
        .lk_pc     (pc[XLEN-1:2]),
        .lk_taken  (lk_taken),
        .lk_target (lk_target),
        .rs_pc     (bus.i_res_pc[XLEN-1:2]),
        .rs_hit    (rs_hit),
        .rs_ctr    (rs_ctr),
        .rs_target (rs_target),
        .wr_en     (wr_en),
        .wr_pc     (bus.i_res_pc[XLEN-1:2]),
        .wr_target (wr_target),
        .wr_ctr    (wr_ctr),
        .wr_uncond (wr_uncond)
    );

    assign pred_npc = lk_taken ? lk_target : pc + XLEN'(4);
    assign fire     = bus.o_pc_valid & bus.i_pc_ready;
    assign mispred  = bus.i_res_valid && (actual_npc != fifo_npc[rd_ptr]);

    always_comb begin
        actual_npc = bus.i_res_pc + XLEN'(4);
        if (bus.i_res_is_jalr)
            actual_npc = (bus.i_res_rs1 + bus.i_res_imm) & JALR_MASK;
        else if (bus.i_res_is_jal || (bus.i_res_is_br && bus.i_res_br_taken))
            actual_npc = bus.i_res_pc + bus.i_res_imm;
    end

    // Jumps always install as strongly-taken unconditional; branches train the counter.
    always_comb begin
        wr_en     = bus.i_res_valid & (bus.i_res_is_jal | bus.i_res_is_jalr | bus.i_res_is_br);
        wr_target = actual_npc;
        wr_ctr    = CTR_ST;
        wr_uncond = 1'b1;
        if (!(bus.i_res_is_jal || bus.i_res_is_jalr) && bus.i_res_is_br) begin
            wr_uncond = 1'b0;
            if (bus.i_res_br_taken) begin
                wr_ctr = rs_hit ? ctr_inc(rs_ctr) : CTR_WT;
            end else begin
                wr_en     = wr_en & rs_hit;
                wr_ctr    = ctr_dec(rs_ctr);
                wr_target = rs_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_VECTOR;
            started     <= 1'b0;
            flush       <= 1'b0;
            mispred_cnt <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            started <= 1'b1;
            flush   <= mispred;
            if (mispred) begin
                // Redirect wins over a same-cycle fetch, which is simply not recorded.
                pc          <= actual_npc;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                mispred_cnt <= mispred_cnt + 32'd1;
            end else begin
                if (fire) begin
                    fifo_pc[wr_ptr]  <= pc;
                    fifo_npc[wr_ptr] <= pred_npc;
                    wr_ptr           <= ptr_next(wr_ptr);
                    pc               <= pred_npc;
                end
                if (bus.i_res_valid)
                    rd_ptr <= ptr_next(rd_ptr);
                count <= count + CW'(fire) - CW'(bus.i_res_valid);
            end
        end
    end

    assign bus.o_pc          = pc;
    assign bus.o_pc_valid    = started && (count != CW'(INFLIGHT));
    assign bus.o_flush       = flush;
    assign bus.o_mispred_cnt = mispred_cnt;

    assert property (@(posedge clk) disable iff (!rst) bus.i_res_valid |-> count != '0);
    assert property (@(posedge clk) disable iff (!rst) bus.i_res_valid |-> bus.i_res_pc == fifo_pc[rd_ptr]);

endmodule
